// File: rtl/uart_alu_if.sv
// Serial line pair of the UART ALU. The slave side is the engine itself;
// the master side is whatever drives rx and listens on tx.
interface uart_alu_if;
  logic rx_i;
  logic tx_o;

  modport slave  (input rx_i, output tx_o);
  modport master (output rx_i, input tx_o);
endinterface

// File: rtl/uart_alu.sv
// UART-attached 32-bit echo/add/mul/div engine: 8N1 receiver, packet parser,
// ALU datapath with restoring divider, and 8N1 transmitter with a 1-byte holding register.
module uart_alu #(
  parameter int ClkFreqHz = 12_000_000,
  parameter int BaudRate  = 115200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  uart_alu_if.slave   bus
);
  localparam int ClksPerBit = ClkFreqHz / BaudRate;
  localparam int CW = $clog2(ClksPerBit + 1);
  localparam logic [CW-1:0] BitLast  = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] HalfLast = CW'(ClksPerBit / 2 - 1);

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [2:0] P_OPCODE = 3'd0, P_RSVD = 3'd1, P_LEN_LO = 3'd2, P_LEN_HI = 3'd3,
                         P_PAYLOAD = 3'd4, P_EXEC = 3'd5, P_RESPOND = 3'd6;
  localparam logic [7:0] OP_ECHO = 8'hEC, OP_ADD = 8'hAD, OP_MUL = 8'h88, OP_DIV = 8'hD1;

  logic            r_rx_s1, r_rx_s2, r_rx_prev, r_rx_vld;
  logic [1:0]      r_rx_st;
  logic [CW-1:0]   r_rx_clk;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_vld  <= 1'b0;
      r_rx_st   <= RX_IDLE;
      r_rx_clk  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_rx_s1   <= bus.rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_vld  <= 1'b0;
      case (r_rx_st)
        RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_st  <= RX_START;
          r_rx_clk <= '0;
        end
        // A start bit that reads high at mid-bit was a glitch; drop the frame.
        RX_START: if (r_rx_clk == HalfLast) begin
          r_rx_clk <= '0;
          r_rx_bit <= '0;
          r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_clk <= r_rx_clk + 1'b1;
        RX_DATA: if (r_rx_clk == BitLast) begin
          r_rx_clk <= '0;
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
        end else r_rx_clk <= r_rx_clk + 1'b1;
        RX_STOP: if (r_rx_clk == BitLast) begin
          r_rx_clk <= '0;
          r_rx_vld <= r_rx_s2;
          r_rx_st  <= RX_IDLE;
        end else r_rx_clk <= r_rx_clk + 1'b1;
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  logic            r_tx_busy, r_tx_o;
  logic [8:0]      r_tx_sh;
  logic [3:0]      r_tx_bit;
  logic [CW-1:0]   r_tx_clk;
  logic [7:0]      r_hold;
  logic            r_hold_vld;
  logic            w_tx_last, w_tx_load;

  // Loading on the last stop-bit cycle keeps consecutive bytes gap-free.
  assign w_tx_last = r_tx_busy && (r_tx_clk == BitLast) && (r_tx_bit == 4'd9);
  assign w_tx_load = r_hold_vld && (!r_tx_busy || w_tx_last);
  assign bus.tx_o  = r_tx_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_busy <= 1'b0;
      r_tx_o    <= 1'b1;
      r_tx_sh   <= '1;
      r_tx_bit  <= '0;
      r_tx_clk  <= '0;
    end else if (w_tx_load) begin
      r_tx_busy <= 1'b1;
      r_tx_o    <= 1'b0;
      r_tx_sh   <= {1'b1, r_hold};
      r_tx_bit  <= '0;
      r_tx_clk  <= '0;
    end else if (r_tx_busy) begin
      if (r_tx_clk == BitLast) begin
        r_tx_clk <= '0;
        if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
        else begin
          r_tx_bit <= r_tx_bit + 4'd1;
          r_tx_o   <= r_tx_sh[0];
          r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
        end
      end else r_tx_clk <= r_tx_clk + 1'b1;
    end
  end

  logic [2:0]  r_st, r_ridx;
  logic [7:0]  r_op, r_len_lo;
  logic [15:0] r_remain;
  logic [23:0] r_word;
  logic [1:0]  r_bidx, r_wcnt;
  logic [31:0] r_acc, r_divisor, r_rem;
  logic [5:0]  r_div_cnt;

  logic [15:0] w_len;
  logic [31:0] w_word, w_res;
  logic [32:0] w_shift, w_diff;
  logic        w_arith, w_div_bad, w_div_busy;

  assign w_len      = {r_rx_sh, r_len_lo};
  assign w_word     = {r_word, r_rx_sh};
  assign w_arith    = (r_op == OP_ADD) || (r_op == OP_MUL) || (r_op == OP_DIV);
  // Restoring step: r_acc doubles as the dividend/quotient shift register.
  assign w_shift    = {r_rem, r_acc[31]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_div_bad  = (r_wcnt != 2'd2) || (r_divisor == 32'd0);
  assign w_div_busy = (r_op == OP_DIV) && !w_div_bad && (r_div_cnt != 6'd32);
  assign w_res      = ((r_op == OP_DIV) && w_div_bad) ? 32'hFFFF_FFFF : r_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st <= P_OPCODE;  r_ridx <= '0;    r_op <= '0;        r_len_lo <= '0;
      r_remain <= '0;    r_word <= '0;    r_bidx <= '0;      r_wcnt <= '0;
      r_acc <= '0;       r_divisor <= '0; r_rem <= '0;       r_div_cnt <= '0;
      r_hold <= '0;      r_hold_vld <= 1'b0;
    end else begin
      if (w_tx_load) r_hold_vld <= 1'b0;
      case (r_st)
        P_OPCODE: if (r_rx_vld) begin
          r_op      <= r_rx_sh;
          r_acc     <= (r_rx_sh == OP_MUL) ? 32'd1 : 32'd0;
          r_divisor <= '0;
          r_rem     <= '0;
          r_div_cnt <= '0;
          r_wcnt    <= '0;
          r_bidx    <= '0;
          r_ridx    <= '0;
          r_st      <= P_RSVD;
        end
        P_RSVD:   if (r_rx_vld) r_st <= P_LEN_LO;
        P_LEN_LO: if (r_rx_vld) begin
          r_len_lo <= r_rx_sh;
          r_st     <= P_LEN_HI;
        end
        P_LEN_HI: if (r_rx_vld) begin
          if (w_len > 16'd4) begin
            r_remain <= w_len - 16'd4;
            r_st     <= P_PAYLOAD;
          end else r_st <= w_arith ? P_EXEC : P_OPCODE;
        end
        P_PAYLOAD: if (r_rx_vld) begin
          r_remain <= r_remain - 16'd1;
          r_word   <= w_word[23:0];
          r_bidx   <= r_bidx + 2'd1;
          if (r_op == OP_ECHO) begin
            r_hold     <= r_rx_sh;
            r_hold_vld <= 1'b1;
          end
          if (r_bidx == 2'd3) begin
            case (r_op)
              OP_ADD: r_acc <= r_acc + w_word;
              OP_MUL: r_acc <= r_acc * w_word;
              OP_DIV: begin
                if (r_wcnt == 2'd0) r_acc <= w_word;
                else if (r_wcnt == 2'd1) r_divisor <= w_word;
                if (r_wcnt != 2'd2) r_wcnt <= r_wcnt + 2'd1;
              end
              default: ;
            endcase
          end
          // Echo returns immediately so the next packet's opcode is not dropped.
          if (r_remain == 16'd1) r_st <= w_arith ? P_EXEC : P_OPCODE;
        end
        P_EXEC: if (w_div_busy) begin
          r_rem     <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
          r_acc     <= {r_acc[30:0], ~w_diff[32]};
          r_div_cnt <= r_div_cnt + 6'd1;
        end else begin
          r_hold     <= w_res[31:24];
          r_hold_vld <= 1'b1;
          r_acc      <= {w_res[23:0], 8'h00};
          r_ridx     <= 3'd1;
          r_st       <= P_RESPOND;
        end
        P_RESPOND: if (!r_hold_vld) begin
          if (r_ridx != 3'd4) begin
            r_hold     <= r_acc[31:24];
            r_hold_vld <= 1'b1;
            r_acc      <= {r_acc[23:0], 8'h00};
            r_ridx     <= r_ridx + 3'd1;
          end else if (!r_tx_busy) r_st <= P_OPCODE;
        end
        default: r_st <= P_OPCODE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu.sv
// Bench for uart_alu: packet vectors sent over rx, tx frames decoded and
// scored against an expected-byte queue, plus reset/glitch sequences.
module tb_uart_alu;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  uart_alu_if bus ();

  uart_alu #(.ClkFreqHz(1_600_000), .BaudRate(100_000)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pkt;
    int           plen;
    logic [63:0]  rsp;
    int           rlen;
  } vec_t;

  vec_t       vecs [14];
  logic [8:0] got_q [$];
  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

  // TX monitor: decode each frame as {stop, data}
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_o == 1'b0) begin
        logic [7:0] d;
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          d[k] = bus.tx_o;
        end
        repeat (CPB) @(negedge clk);
        got_q.push_back({bus.tx_o, d});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      bus.rx_i = b[k];
      repeat (CPB) @(negedge clk);
    end
    bus.rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_pkt(input vec_t v, input int n);
    for (int k = 0; k < n; k++) send_byte(v.pkt[127 - 8*k -: 8]);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    for (int k = 0; k < v.rlen; k++) exp_q.push_back(v.rsp[63 - 8*k -: 8]);
    send_pkt(v, v.plen);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() != 0 && got_q.size() != 0)
      chk(name, {23'h0, got_q.pop_front()}, {23'h0, 1'b1, exp_q.pop_front()});
    exp_q.delete();
    repeat (30 * CPB) @(negedge clk);
    chk({name, "_extra"}, got_q.size(), 0);
    got_q.delete();
  endtask

  initial begin
    int n;
    bus.rx_i = 1'b1;
    rst_n    = 1'b0;
    vecs[0]  = '{128'hD1000C00_0000000C_00000002_00000000, 12, 64'h00000006_00000000, 4};
    vecs[1]  = '{128'hEC000C00_DEADBEEF_1A9831AB_00000000, 12, 64'hDEADBEEF_1A9831AB, 8};
    vecs[2]  = '{128'hAD000C00_00000001_00000002_00000000, 12, 64'h00000003_00000000, 4};
    vecs[3]  = '{128'h88000C00_00000003_00000002_00000000, 12, 64'h00000006_00000000, 4};
    vecs[4]  = '{128'hAD000C00_FFFFFFFF_00000002_00000000, 12, 64'h00000001_00000000, 4};
    vecs[5]  = '{128'hD1000C00_00000005_00000000_00000000, 12, 64'hFFFFFFFF_00000000, 4};
    vecs[6]  = '{128'h55000600_AABB0000_00000000_00000000, 6,  64'h0, 0};
    vecs[7]  = '{128'hEC000500_42000000_00000000_00000000, 5,  64'h42000000_00000000, 1};
    vecs[8]  = '{128'hAD000E00_00000005_00000007_99880000, 14, 64'h0000000C_00000000, 4};
    vecs[9]  = '{128'h88000400_00000000_00000000_00000000, 4,  64'h00000001_00000000, 4};
    vecs[10] = '{128'hAD000200_00000000_00000000_00000000, 4,  64'h00000000_00000000, 4};
    vecs[11] = '{128'hD1001000_FFFFFFFF_00000010_12345678, 16, 64'h0FFFFFFF_00000000, 4};
    vecs[12] = '{128'h88001000_00010001_00010001_00000003, 16, 64'h00060003_00000000, 4};
    vecs[13] = '{128'hD1000400_00000000_00000000_00000000, 4,  64'hFFFFFFFF_00000000, 4};

    repeat (10) @(negedge clk);
    chk("reset_tx", {31'h0, bus.tx_o}, 32'd1);
    rst_n = 1'b1;
    repeat (20000) @(negedge clk);
    chk("idle_quiet", got_q.size(), 0);
    chk("idle_tx", {31'h0, bus.tx_o}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Quarter-bit low glitch must not be taken as a byte
    bus.rx_i = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    run_vec(vecs[7], "glitch_echo");

    // Reset in the middle of an add payload
    send_pkt(vecs[2], 6);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("midpkt_reset_tx", {31'h0, bus.tx_o}, 32'd1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_vec(vecs[2], "post_reset_add");

    // Reset in the middle of a response: tx must rise without a clock edge
    send_pkt(vecs[2], 12);
    n = 0;
    while (bus.tx_o == 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_started", {31'h0, bus.tx_o}, 32'd0);
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_tx_high", {31'h0, bus.tx_o}, 32'd1);
    repeat (12 * CPB) @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_vec(vecs[2], "after_abort_add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
